// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
//  Module      : spi_target
//  Description : SPI mode-0 target. Oversamples csn/sclk/mosi on clk, emits
//                each received byte as a one-cycle pulse and shifts transmit
//                bytes out of a one-entry holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_target #(
  parameter logic [7:0] DEFAULT_TX  = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       spi_csn_i,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains; the last stage is the clk-domain view of each pin.
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   csn_prev_q, sclk_prev_q;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       byte_done_q, byte_done_d;
  logic       miso_q, miso_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;

  logic       csn_s, sclk_s, mosi_s;
  logic       csn_fall, csn_rise, sclk_rise, sclk_fall;
  logic       do_load;
  logic [7:0] load_byte;
  logic [7:0] rx_next;

  // Shift each pin one stage deeper into the clk domain.
  always_comb begin
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0],  spi_csn_i};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
  end

  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csn_fall  = csn_prev_q & ~csn_s;
  assign csn_rise  = ~csn_prev_q & csn_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // Byte to present at a byte boundary: held data if any, otherwise the filler.
  assign load_byte = hold_full_q ? hold_q : DEFAULT_TX;
  assign rx_next   = {rx_shift_q[6:0], mosi_s};

  // Frame sequencing, shift registers and the tx holding-register handshake.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    byte_done_d = byte_done_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    do_load     = 1'b0;

    // csn edges take priority over any coincident sclk edge.
    if (csn_fall) begin
      state_d     = ST_ACTIVE;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      do_load     = 1'b1;
      miso_d      = load_byte[7];
    end else if (csn_rise) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      rx_shift_d  = 8'h00;
      byte_done_d = 1'b0;
      miso_d      = 1'b1;
    end else if (state_q == ST_ACTIVE) begin
      if (sclk_rise) begin
        rx_shift_d = rx_next;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_data_d   = rx_next;
          rx_valid_d  = 1'b1;
          byte_done_d = 1'b1;
        end
      end else if (sclk_fall) begin
        if (byte_done_q) begin
          byte_done_d = 1'b0;
          do_load     = 1'b1;
          miso_d      = load_byte[7];
        end else begin
          tx_shift_d = {tx_shift_q[6:0], 1'b1};
          miso_d     = tx_shift_q[6];
        end
      end
    end

    if (do_load) begin
      tx_shift_d = load_byte;
      if (hold_full_q) hold_full_d = 1'b0;
      else             underrun_d  = 1'b1;
    end

    // Acceptance is based on this cycle's ready, so a byte offered while the
    // holding register is being drained waits until the next cycle.
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  // Register all state; async reset returns every output to its idle value.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      csn_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= DEFAULT_TX;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      byte_done_q <= 1'b0;
      miso_q      <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      csn_sync_q  <= csn_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      csn_prev_q  <= csn_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      byte_done_q <= byte_done_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = (state_q == ST_ACTIVE);
  assign busy_o        = (state_q == ST_ACTIVE);
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = ~hold_full_q;
  assign tx_underrun_o = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_target
//  Description : Directed self-checking bench for spi_target acting as a
//                mode-0 SPI master at sclk = clk/8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_target;

  logic       clk;
  logic       reset_n;
  logic       spi_csn, spi_sclk, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_underrun, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];
  logic [7:0] rx_q [$];
  int         underrun_cnt = 0;

  spi_target #(.DEFAULT_TX(8'hFF), .SYNC_STAGES(2)) u_dut (
    .clk           (clk),
    .reset_n_i     (reset_n),
    .spi_csn_i     (spi_csn),
    .spi_sclk_i    (spi_sclk),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso),
    .spi_miso_oe_o (spi_miso_oe),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .tx_underrun_o (tx_underrun),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every cycle where rx_valid / tx_underrun is high (sampled mid-cycle).
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_underrun) underrun_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    int t;
    t = 0;
    while (!tx_ready && t < 500) begin
      wait_clk(1);
      t++;
    end
    check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  // Mode-0 master: mosi set on the falling edge, miso sampled on the rising
  // edge; csn rises together with the last sclk fall.
  task automatic spi_xfer(input int nbits);
    spi_csn = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      int b;
      int k;
      b = i / 8;
      k = 7 - (i % 8);
      spi_mosi = m_tx[b][k];
      wait_clk(4);
      spi_sclk = 1'b1;
      m_rx[b][k] = spi_miso;
      wait_clk(4);
      spi_sclk = 1'b0;
      if (i == nbits - 1) spi_csn = 1'b1;
    end
    spi_csn = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    int rx0;
    int ur0;
    reset_n  = 1'b0;
    spi_csn  = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    wait_clk(3);

    check("rst_miso",     {31'd0, spi_miso},    32'd1);
    check("rst_oe",       {31'd0, spi_miso_oe}, 32'd0);
    check("rst_rx_data",  {24'd0, rx_data},     32'd0);
    check("rst_rx_valid", {31'd0, rx_valid},    32'd0);
    check("rst_tx_ready", {31'd0, tx_ready},    32'd1);
    check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    check("rst_busy",     {31'd0, busy},        32'd0);
    reset_n = 1'b1;
    wait_clk(4);

    // 1: preloaded A5, master sends 3C
    push_tx(8'hA5);
    check("t1_ready_low", {31'd0, tx_ready}, 32'd0);
    rx0 = rx_q.size(); ur0 = underrun_cnt;
    m_tx[0] = 8'h3C;
    spi_xfer(8);
    check("t1_rx_count", rx_q.size() - rx0, 32'd1);
    check("t1_rx_data",  {24'd0, rx_q[rx_q.size()-1]}, 32'h3C);
    check("t1_miso",     {24'd0, m_rx[0]}, 32'hA5);
    check("t1_underrun", underrun_cnt - ur0, 32'd0);
    check("t1_ready",    {31'd0, tx_ready}, 32'd1);

    // 2: no preload, underrun once, filler FF
    rx0 = rx_q.size(); ur0 = underrun_cnt;
    m_tx[0] = 8'h00;
    spi_xfer(8);
    check("t2_rx_data",  {24'd0, rx_q[rx_q.size()-1]}, 32'h00);
    check("t2_miso",     {24'd0, m_rx[0]}, 32'hFF);
    check("t2_underrun", underrun_cnt - ur0, 32'd1);

    // 3: three-byte frame with tx refilled while ready
    push_tx(8'h10);
    rx0 = rx_q.size(); ur0 = underrun_cnt;
    m_tx[0] = 8'h01; m_tx[1] = 8'h02; m_tx[2] = 8'h03;
    fork
      spi_xfer(24);
      begin
        push_tx(8'h20);
        push_tx(8'h30);
      end
    join
    check("t3_rx_count", rx_q.size() - rx0, 32'd3);
    check("t3_rx0", {24'd0, rx_q[rx0]},     32'h01);
    check("t3_rx1", {24'd0, rx_q[rx0 + 1]}, 32'h02);
    check("t3_rx2", {24'd0, rx_q[rx0 + 2]}, 32'h03);
    check("t3_miso0", {24'd0, m_rx[0]}, 32'h10);
    check("t3_miso1", {24'd0, m_rx[1]}, 32'h20);
    check("t3_miso2", {24'd0, m_rx[2]}, 32'h30);
    check("t3_underrun", underrun_cnt - ur0, 32'd0);

    // 4: 5-bit aborted frame, then full 5A
    rx0 = rx_q.size();
    m_tx[0] = 8'hC7;
    spi_xfer(5);
    check("t4_partial_rx", rx_q.size() - rx0, 32'd0);
    m_tx[0] = 8'h5A;
    spi_xfer(8);
    check("t4_rx_count", rx_q.size() - rx0, 32'd1);
    check("t4_rx_data",  {24'd0, rx_data}, 32'h5A);

    // 5: reset in the middle of a byte
    push_tx(8'h00);
    spi_csn = 1'b0;
    wait_clk(8);
    check("t5_busy_mid", {31'd0, busy}, 32'd1);
    push_tx(8'h77);
    spi_mosi = 1'b1;
    wait_clk(4);
    spi_sclk = 1'b1;
    wait_clk(4);
    spi_sclk = 1'b0;
    wait_clk(6);
    check("t5_miso_mid",  {31'd0, spi_miso}, 32'd0);
    check("t5_ready_mid", {31'd0, tx_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("t5_rst_miso",  {31'd0, spi_miso},    32'd1);
    check("t5_rst_oe",    {31'd0, spi_miso_oe}, 32'd0);
    check("t5_rst_busy",  {31'd0, busy},        32'd0);
    check("t5_rst_ready", {31'd0, tx_ready},    32'd1);
    check("t5_rst_rx",    {24'd0, rx_data},     32'd0);
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(8);
    push_tx(8'hC3);
    rx0 = rx_q.size(); ur0 = underrun_cnt;
    m_tx[0] = 8'h96;
    spi_xfer(8);
    check("t5_rx_data",  {24'd0, rx_data}, 32'h96);
    check("t5_rx_count", rx_q.size() - rx0, 32'd1);
    check("t5_miso",     {24'd0, m_rx[0]}, 32'hC3);
    check("t5_underrun", underrun_cnt - ur0, 32'd0);

    // 6: sclk toggling with csn high is ignored
    rx0 = rx_q.size();
    for (int i = 0; i < 16; i++) begin
      spi_mosi = i[0];
      wait_clk(4);
      spi_sclk = 1'b1;
      wait_clk(4);
      spi_sclk = 1'b0;
      if (i == 8) begin
        check("t6_oe",   {31'd0, spi_miso_oe}, 32'd0);
        check("t6_busy", {31'd0, busy},        32'd0);
      end
    end
    wait_clk(8);
    check("t6_rx_count", rx_q.size() - rx0, 32'd0);
    check("t6_oe_end",   {31'd0, spi_miso_oe}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
